pong_game_sequencer: RTL
========================

// Module: pong_game_sequencer
// PURPOSE
//   Game-level Moore FSM sequencing ball and paddle motion: attract/idle, serve countdown, play,
//   pause, point hold, game over. Keeps both scores, chooses serve direction, declares the winner.
//   Sits between keycode/ball-miss sources and the ball/paddle motion blocks; runs on the 50 MHz
//   system clock, with frame_tick a one-Clk pulse per VGA frame.
// PARAMETERS
//   WIN_SCORE     7      points to win; 1..15
//   SERVE_FRAMES  60     frames held in SERVE before play; 1..255
//   POINT_FRAMES  90     frames held in POINT after a miss; 1..255
//   KEY_START     8'h2C  keycode for start/restart (space)
//   KEY_PAUSE     8'h13  keycode for pause toggle (P)
// PORTS
//   Clk         in   1  system clock, 50 MHz
//   Reset       in   1  synchronous, active-high
//   frame_tick  in   1  one-Clk pulse per frame
//   keycode     in   8  current USB keycode, level, 0 = none
//   miss_left   in   1  one-Clk pulse: ball passed left edge; player 1 missed
//   miss_right  in   1  one-Clk pulse: ball passed right edge; player 2 missed
//   ball_reset  out  1  hold ball at centre
//   ball_en     out  1  allow ball motion
//   paddle_en   out  1  allow paddle motion
//   serve_dir   out  1  0 = serve toward player 1 (left), 1 = toward player 2 (right)
//   score1      out  4  player 1 score, binary
//   score2      out  4  player 2 score, binary
//   game_over   out  1  high only in GAMEOVER
//   winner      out  1  0 = player 1, 1 = player 2; valid while game_over
//   state       out  3  IDLE=0 SERVE=1 PLAY=2 PAUSE=3 POINT=4 GAMEOVER=5
// BEHAVIOUR
//   - Reset, from any state including mid-countdown: state=IDLE, score1=score2=0, serve_dir=0,
//     winner=0, frame counter=0; both key-press history regs set to 1.
//   - Key press = (keycode==KEY_x) this cycle AND history reg 0. History reg <= (keycode==KEY_x)
//     every cycle. A key held through reset must be released before it counts.
//   - Outputs are Moore decodes of the state register. They change one Clk after the sampling edge.
//     IDLE: ball_reset=1, rest 0. SERVE: ball_reset=1, paddle_en=1. PLAY: ball_en=1, paddle_en=1.
//     PAUSE/POINT/GAMEOVER: all 0; the ball freezes in place.
//   - IDLE --start--> SERVE, scores cleared, serve_dir=0, counter=0.
//   - SERVE: counter +1 per frame_tick. On a frame_tick with counter==SERVE_FRAMES-1 -> PLAY, counter=0.
//   - PLAY, on a single miss:
//     miss_right -> score1+1, serve_dir=1. miss_left -> score2+1, serve_dir=0.
//     Next state is GAMEOVER if the incremented score == WIN_SCORE, else POINT.
//     GAMEOVER: winner=0 when score1 hit WIN_SCORE, 1 when score2 did.
//   - PLAY, miss_left and miss_right in the same cycle: no score change, serve_dir unchanged -> POINT.
//   - PLAY, pause press with no miss that cycle -> PAUSE. A miss on the same cycle wins; the pause press is dropped.
//   - PAUSE: pause press -> PLAY. Misses ignored.
//   - POINT: counter +1 per frame_tick. On a frame_tick with counter==POINT_FRAMES-1 -> SERVE, counter=0.
//   - GAMEOVER: start press -> SERVE, scores cleared, serve_dir=0, winner held until the next GAMEOVER.
//   - Misses outside PLAY are ignored. Start press outside IDLE/GAMEOVER is ignored.
//   - Scores never exceed WIN_SCORE. Counter is 8 bits, cleared on every state entry, no wrap.
// TESTING
//   1 Reset with keycode=8'h2C held for 5 cycles after release -> state stays 0.
//     Release, then press 8'h2C -> state=1 two Clks later; scores 0; ball_reset=1.
//   2 In SERVE, 59 frame_ticks -> state=1; 60th tick -> state=2, ball_en=1, ball_reset=0.
//   3 In PLAY, miss_right pulse -> score1=1, serve_dir=1, state=4. After 90 ticks -> state=1.
//   4 At score2=6, miss_left -> score2=7, state=5, game_over=1, winner=1.
//     miss_right in GAMEOVER -> scores unchanged. Start press -> state=1, scores 0.
//   5 In PLAY, miss_left and miss_right in the same cycle -> scores unchanged, state=4.
//     8'h13 press and miss_right in the same cycle -> score1+1, state=4, not PAUSE.
//   6 In PAUSE, miss pulses and 200 frame_ticks -> nothing changes. Pause press -> state=2.
//     Reset asserted mid-POINT -> state=0, scores 0 next Clk.

Source files
------------

// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer: game-level Moore FSM for a two-player pong.
// It sequences attract/idle, serve countdown, play, pause, point hold and game over.
// It also keeps both scores, picks the serve direction and records the winner.
// Internal state is held in *_q registers. Every output port is a registered copy
// of that state, so outputs follow the sampling edge by one Clk.
//
// Ports
//   Clk         in   1  system clock
//   Reset       in   1  synchronous, active-high
//   frame_tick  in   1  one-Clk pulse per video frame
//   keycode     in   8  current keycode (level, 0 = none)
//   miss_left   in   1  ball passed left edge (player 1 missed)
//   miss_right  in   1  ball passed right edge (player 2 missed)
//   ball_reset  out  1  hold ball at centre
//   ball_en     out  1  allow ball motion
//   paddle_en   out  1  allow paddle motion
//   serve_dir   out  1  0 = toward player 1, 1 = toward player 2
//   score1      out  4  player 1 score
//   score2      out  4  player 2 score
//   game_over   out  1  high only in GAMEOVER
//   winner      out  1  0 = player 1, 1 = player 2
//   state       out  3  IDLE=0 SERVE=1 PLAY=2 PAUSE=3 POINT=4 GAMEOVER=5
`timescale 1ns/1ps
module pong_game_sequencer #(
   parameter int unsigned WIN_SCORE    = 7,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned POINT_FRAMES = 90,
   parameter logic [7:0]  KEY_START    = 8'h2C,
   parameter logic [7:0]  KEY_PAUSE    = 8'h13
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic       ball_reset,
   output logic       ball_en,
   output logic       paddle_en,
   output logic       serve_dir,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state
);

   localparam int unsigned SCORE_W = 4;
   localparam int unsigned CNT_W   = 8;
   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SERVE    = 3'd1,
      ST_PLAY     = 3'd2,
      ST_PAUSE    = 3'd3,
      ST_POINT    = 3'd4,
      ST_GAMEOVER = 3'd5
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [SCORE_W-1:0]   score1_q;
   logic [SCORE_W-1:0]   score2_q;
   logic                 serve_dir_q;
   logic                 winner_q;
   logic                 start_hist_q;
   logic                 pause_hist_q;

   logic                 start_hit;
   logic                 pause_hit;
   logic                 start_press;
   logic                 pause_press;
   logic [SCORE_W-1:0]   score1_inc;
   logic [SCORE_W-1:0]   score2_inc;

   // Rising-edge key detect; history regs come out of reset set so a held key is ignored.
   assign start_hit   = (keycode == KEY_START);
   assign pause_hit   = (keycode == KEY_PAUSE);
   assign start_press = start_hit && !start_hist_q;
   assign pause_press = pause_hit && !pause_hist_q;
   assign score1_inc  = score1_q + SCORE_W'(1);
   assign score2_inc  = score2_q + SCORE_W'(1);

   // State, counter, scores, and the registered Moore outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         score1_q     <= '0;
         score2_q     <= '0;
         serve_dir_q  <= 1'b0;
         winner_q     <= 1'b0;
         start_hist_q <= 1'b1;
         pause_hist_q <= 1'b1;
         ball_reset   <= 1'b1;
         ball_en      <= 1'b0;
         paddle_en    <= 1'b0;
         game_over    <= 1'b0;
         serve_dir    <= 1'b0;
         score1       <= '0;
         score2       <= '0;
         winner       <= 1'b0;
         state        <= 3'(ST_IDLE);
      end else begin
         start_hist_q <= start_hit;
         pause_hist_q <= pause_hit;

         unique case (state_q)
            ST_IDLE: begin
               if (start_press) begin
                  state_q     <= ST_SERVE;
                  cnt_q       <= '0;
                  score1_q    <= '0;
                  score2_q    <= '0;
                  serve_dir_q <= 1'b0;
               end
            end
            ST_SERVE: begin
               if (frame_tick) begin
                  if (cnt_q == SERVE_LAST) begin
                     state_q <= ST_PLAY;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_PLAY: begin
               // A miss outranks a pause press in the same cycle; a double miss is a void point.
               if (miss_left && miss_right) begin
                  state_q <= ST_POINT;
                  cnt_q   <= '0;
               end else if (miss_right) begin
                  score1_q    <= score1_inc;
                  serve_dir_q <= 1'b1;
                  cnt_q       <= '0;
                  if (score1_inc == WIN_VAL) begin
                     state_q  <= ST_GAMEOVER;
                     winner_q <= 1'b0;
                  end else begin
                     state_q <= ST_POINT;
                  end
               end else if (miss_left) begin
                  score2_q    <= score2_inc;
                  serve_dir_q <= 1'b0;
                  cnt_q       <= '0;
                  if (score2_inc == WIN_VAL) begin
                     state_q  <= ST_GAMEOVER;
                     winner_q <= 1'b1;
                  end else begin
                     state_q <= ST_POINT;
                  end
               end else if (pause_press) begin
                  state_q <= ST_PAUSE;
                  cnt_q   <= '0;
               end
            end
            ST_PAUSE: begin
               if (pause_press) begin
                  state_q <= ST_PLAY;
                  cnt_q   <= '0;
               end
            end
            ST_POINT: begin
               if (frame_tick) begin
                  if (cnt_q == POINT_LAST) begin
                     state_q <= ST_SERVE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_GAMEOVER: begin
               if (start_press) begin
                  state_q     <= ST_SERVE;
                  cnt_q       <= '0;
                  score1_q    <= '0;
                  score2_q    <= '0;
                  serve_dir_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase

         // Output stage: decode of the current state register.
         ball_reset <= (state_q == ST_IDLE) || (state_q == ST_SERVE);
         ball_en    <= (state_q == ST_PLAY);
         paddle_en  <= (state_q == ST_SERVE) || (state_q == ST_PLAY);
         game_over  <= (state_q == ST_GAMEOVER);
         serve_dir  <= serve_dir_q;
         score1     <= score1_q;
         score2     <= score2_q;
         winner     <= winner_q;
         state      <= 3'(state_q);
      end
   end

endmodule
